// File: rtl/id_stage_param.sv
// Decode stage: register file with write-through, instruction decode, load-use stall
// detection and the ID/EX pipeline register with flush/hold/stall priority.
module id_stage_param #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pcplus4_d,
  input  logic            valid_d,
  input  logic            regwrite_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  input  logic            memread_e_in,
  input  logic [4:0]      rd_e_in,
  input  logic            hold_e,
  input  logic            flush_e,
  output logic            stall_d,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pcplus4_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_e,
  output logic [4:0]      rd_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [2:0]      alucontrol_e,
  output logic [1:0]      resultsrc_e,
  output logic            regwrite_e,
  output logic            memwrite_e,
  output logic            memread_e,
  output logic            jump_e,
  output logic            branch_e,
  output logic            alusrc_e,
  output logic            valid_e
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      alucontrol;
    logic [1:0]      resultsrc;
    logic            regwrite;
    logic            memwrite;
    logic            memread;
    logic            jump;
    logic            branch;
    logic            alusrc;
    logic            valid;
  } idex_t;

  logic [XLEN-1:0] rf_q [NREGS];
  idex_t           dec;
  idex_t           idex_d;
  idex_t           idex_q;

  // x0 and addresses beyond the implemented file are hard-wired to zero
  function automatic logic legal_addr(input logic [4:0] a);
    return (a != 5'd0) && ({27'd0, a} < NREGS);
  endfunction

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
    if (!legal_addr(a))
      return '0;
    if (regwrite_w && (rd_w == a))
      return result_w;
    return rf_q[a[AW-1:0]];
  endfunction

  function automatic logic [2:0] alu_code(input logic [2:0] funct3, input logic sub);
    case (funct3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b010:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (regwrite_w && legal_addr(rd_w)) begin
      rf_q[rd_w[AW-1:0]] <= result_w;
    end
  end

  logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  assign imm_i = {{(XLEN-12){instr_d[31]}}, instr_d[31:20]};
  assign imm_s = {{(XLEN-12){instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
  assign imm_b = {{(XLEN-13){instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25],
                  instr_d[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20],
                  instr_d[30:21], 1'b0};

  always_comb begin
    dec         = '0;
    dec.pc      = pc_d;
    dec.pcplus4 = pcplus4_d;
    dec.rd1     = rf_read(instr_d[19:15]);
    dec.rd2     = rf_read(instr_d[24:20]);
    dec.rd      = instr_d[11:7];
    dec.rs1     = instr_d[19:15];
    dec.rs2     = instr_d[24:20];
    dec.valid   = 1'b1;
    case (instr_d[6:0])
      7'b0110011: begin
        dec.regwrite   = 1'b1;
        dec.alucontrol = alu_code(instr_d[14:12], instr_d[30]);
      end
      7'b0010011: begin
        dec.regwrite   = 1'b1;
        dec.alusrc     = 1'b1;
        dec.alucontrol = alu_code(instr_d[14:12], 1'b0);
        dec.imm        = imm_i;
      end
      7'b0000011: begin
        dec.regwrite  = 1'b1;
        dec.memread   = 1'b1;
        dec.alusrc    = 1'b1;
        dec.resultsrc = 2'b01;
        dec.imm       = imm_i;
      end
      7'b0100011: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.imm      = imm_s;
      end
      7'b1100011: begin
        dec.branch     = 1'b1;
        dec.alucontrol = 3'b001;
        dec.imm        = imm_b;
      end
      7'b1101111: begin
        dec.jump      = 1'b1;
        dec.regwrite  = 1'b1;
        dec.resultsrc = 2'b10;
        dec.imm       = imm_j;
      end
      default: ;
    endcase
  end

  assign stall_d = reset && memread_e_in && (rd_e_in != 5'd0) && valid_d &&
                   ((rd_e_in == instr_d[19:15]) || (rd_e_in == instr_d[24:20]));

  // ID/EX boundary: flush beats hold, hold beats stall/invalid bubbles
  always_comb begin
    idex_d = idex_q;
    if (flush_e)
      idex_d = '0;
    else if (hold_e)
      idex_d = idex_q;
    else if (stall_d || !valid_d)
      idex_d = '0;
    else
      idex_d = dec;
  end

  always_ff @(posedge clk) begin
    if (!reset) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign pc_e         = idex_q.pc;
  assign pcplus4_e    = idex_q.pcplus4;
  assign rd1_e        = idex_q.rd1;
  assign rd2_e        = idex_q.rd2;
  assign imm_e        = idex_q.imm;
  assign rd_e         = idex_q.rd;
  assign rs1_e        = idex_q.rs1;
  assign rs2_e        = idex_q.rs2;
  assign alucontrol_e = idex_q.alucontrol;
  assign resultsrc_e  = idex_q.resultsrc;
  assign regwrite_e   = idex_q.regwrite;
  assign memwrite_e   = idex_q.memwrite;
  assign memread_e    = idex_q.memread;
  assign jump_e       = idex_q.jump;
  assign branch_e     = idex_q.branch;
  assign alusrc_e     = idex_q.alusrc;
  assign valid_e      = idex_q.valid;

endmodule

// File: tb/tb_id_stage_param.sv
// Scoreboard bench for id_stage_param (XLEN=64, NREGS=16): a driver pushes the
// expected ID/EX contents from a reference model, a monitor pops and compares.
module tb_id_stage_param;
  localparam int XLEN  = 64;
  localparam int NREGS = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d, pcplus4_d;
  logic            valid_d, regwrite_w, hold_e, flush_e;
  logic [4:0]      rd_w;
  logic [XLEN-1:0] result_w;
  logic            stall_d;
  logic [XLEN-1:0] pc_e, pcplus4_e, rd1_e, rd2_e, imm_e;
  logic [4:0]      rd_e, rs1_e, rs2_e;
  logic [2:0]      alucontrol_e;
  logic [1:0]      resultsrc_e;
  logic            regwrite_e, memwrite_e, memread_e, jump_e, branch_e, alusrc_e, valid_e;

  always #5 clk = ~clk;

  id_stage_param #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .valid_d(valid_d), .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
    .memread_e_in(memread_e), .rd_e_in(rd_e), .hold_e(hold_e), .flush_e(flush_e),
    .stall_d(stall_d), .pc_e(pc_e), .pcplus4_e(pcplus4_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_e(imm_e), .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .alucontrol_e(alucontrol_e),
    .resultsrc_e(resultsrc_e), .regwrite_e(regwrite_e), .memwrite_e(memwrite_e),
    .memread_e(memread_e), .jump_e(jump_e), .branch_e(branch_e), .alusrc_e(alusrc_e),
    .valid_e(valid_e)
  );

  typedef struct {
    logic [63:0] pc, pcp4, rd1, rd2, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  alu;
    logic [1:0]  rsrc;
    logic        regw, memw, memr, jump, branch, alusrc, valid;
  } ex_t;

  ex_t         sb_q[$];
  ex_t         me;
  logic [63:0] mreg [32];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ex_t ex_zero();
    ex_t e;
    e.pc = '0; e.pcp4 = '0; e.rd1 = '0; e.rd2 = '0; e.imm = '0;
    e.rd = '0; e.rs1 = '0; e.rs2 = '0; e.alu = '0; e.rsrc = '0;
    e.regw = 0; e.memw = 0; e.memr = 0; e.jump = 0; e.branch = 0; e.alusrc = 0; e.valid = 0;
    return e;
  endfunction

  function automatic logic [63:0] sext(input logic [63:0] v, input int n);
    logic signed [63:0] s;
    s = v;
    if (v[n-1]) s = s - (64'sd1 <<< n);
    return s;
  endfunction

  // Architectural read as seen by an instruction in decode this cycle
  function automatic logic [63:0] mread(input logic [4:0] r, input logic rw,
                                        input logic [4:0] rdw, input logic [63:0] res);
    if (r == 0 || int'(r) >= NREGS) return 64'd0;
    if (rw && rdw == r) return res;
    return mreg[r];
  endfunction

  function automatic ex_t ref_decode(input logic [31:0] ins, input logic [63:0] pc,
                                     input logic [63:0] a, input logic [63:0] b);
    ex_t e;
    logic [2:0] f3;
    e = ex_zero();
    e.pc = pc; e.pcp4 = pc + 64'd4; e.rd1 = a; e.rd2 = b;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.valid = 1;
    f3 = ins[14:12];
    case (ins[6:0])
      7'b0110011, 7'b0010011: begin
        e.regw = 1;
        e.alusrc = (ins[6:0] == 7'b0010011);
        if (f3 == 3'd7) e.alu = 3'd2;        // and
        else if (f3 == 3'd6) e.alu = 3'd3;   // or
        else if (f3 == 3'd2) e.alu = 3'd5;   // slt
        else if (f3 == 3'd0 && ins[30] && !e.alusrc) e.alu = 3'd1;
        else e.alu = 3'd0;
        if (e.alusrc) e.imm = sext({52'd0, ins[31:20]}, 12);
      end
      7'b0000011: begin
        e.regw = 1; e.memr = 1; e.alusrc = 1; e.rsrc = 2'b01;
        e.imm = sext({52'd0, ins[31:20]}, 12);
      end
      7'b0100011: begin
        e.memw = 1; e.alusrc = 1;
        e.imm = sext({52'd0, ins[31:25], ins[11:7]}, 12);
      end
      7'b1100011: begin
        e.branch = 1; e.alu = 3'd1;
        e.imm = sext({51'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
      end
      7'b1101111: begin
        e.jump = 1; e.regw = 1; e.rsrc = 2'b10;
        e.imm = sext({43'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic step(input logic rst, input logic [31:0] ins, input logic vld,
                      input logic hld, input logic fl, input logic rw,
                      input logic [4:0] rdw, input logic [63:0] res);
    logic [4:0]  r1, r2;
    logic        exp_stall;
    logic [63:0] pc;
    ex_t         nxt;
    @(negedge clk);
    pc = {$urandom, $urandom};
    reset = rst; instr_d = ins; valid_d = vld; hold_e = hld; flush_e = fl;
    regwrite_w = rw; rd_w = rdw; result_w = res; pc_d = pc; pcplus4_d = pc + 64'd4;
    #1;
    r1 = ins[19:15]; r2 = ins[24:20];
    exp_stall = rst && me.memr && me.rd != 0 && vld && (me.rd == r1 || me.rd == r2);
    chk("stall_d", {63'd0, stall_d}, {63'd0, exp_stall});
    if (!rst || fl)                nxt = ex_zero();
    else if (hld)                  nxt = me;
    else if (exp_stall || !vld)    nxt = ex_zero();
    else nxt = ref_decode(ins, pc, mread(r1, rw, rdw, res), mread(r2, rw, rdw, res));
    sb_q.push_back(nxt);
    me = nxt;
    if (!rst) begin
      for (int i = 0; i < 32; i++) mreg[i] = '0;
    end else if (rw && rdw != 0 && int'(rdw) < NREGS) begin
      mreg[rdw] = res;
    end
  endtask

  task automatic go(input logic [31:0] ins);
    step(1, ins, 1, 0, 0, 0, 5'd0, 64'd0);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [7];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1110011};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 6)];
    if ($urandom_range(0, 3) != 0) w[19:15] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 3) != 0) w[24:20] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 3) != 0) w[11:7]  = 5'($urandom_range(0, 7));
    return w;
  endfunction

  // Monitor: one ID/EX record is expected after every active edge the driver issued
  initial begin
    ex_t e;
    forever begin
      @(posedge clk); #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_e", pc_e, e.pc);           chk("pcplus4_e", pcplus4_e, e.pcp4);
        chk("rd1_e", rd1_e, e.rd1);        chk("rd2_e", rd2_e, e.rd2);
        chk("imm_e", imm_e, e.imm);        chk("rd_e", 64'(rd_e), 64'(e.rd));
        chk("rs1_e", 64'(rs1_e), 64'(e.rs1));
        chk("rs2_e", 64'(rs2_e), 64'(e.rs2));
        chk("alucontrol_e", 64'(alucontrol_e), 64'(e.alu));
        chk("resultsrc_e", 64'(resultsrc_e), 64'(e.rsrc));
        chk("ctl_e", {57'd0, regwrite_e, memwrite_e, memread_e, jump_e, branch_e, alusrc_e,
                      valid_e},
                     {57'd0, e.regw, e.memw, e.memr, e.jump, e.branch, e.alusrc, e.valid});
      end
    end
  end

  initial begin
    logic [31:0] add_x6, lw_x7, add_x8, sw_x8, add_x9, add_x10, beq_m8, add_x11, lw_x3, add_x4;
    me = ex_zero();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    reset = 0; instr_d = '0; valid_d = 0; hold_e = 0; flush_e = 0;
    regwrite_w = 0; rd_w = '0; result_w = '0; pc_d = '0; pcplus4_d = '0;

    add_x6  = {7'd0, 5'd0, 5'd5, 3'd0, 5'd6, 7'b0110011};
    lw_x7   = {12'd0, 5'd1, 3'b010, 5'd7, 7'b0000011};
    add_x8  = {7'd0, 5'd1, 5'd7, 3'd0, 5'd8, 7'b0110011};
    sw_x8   = {7'd0, 5'd8, 5'd2, 3'b010, 5'd4, 7'b0100011};
    add_x9  = {7'd0, 5'd2, 5'd1, 3'd0, 5'd9, 7'b0110011};
    add_x10 = {7'd0, 5'd0, 5'd0, 3'd0, 5'd10, 7'b0110011};
    beq_m8  = {1'b1, 6'b111111, 5'd2, 5'd1, 3'd0, 4'b1100, 1'b1, 7'b1100011};
    add_x11 = {7'd0, 5'd20, 5'd20, 3'd0, 5'd11, 7'b0110011};
    lw_x3   = {12'd0, 5'd1, 3'b010, 5'd3, 7'b0000011};
    add_x4  = {7'd0, 5'd3, 5'd3, 3'd0, 5'd4, 7'b0110011};

    step(0, add_x6, 1, 1, 1, 1, 5'd3, 64'hAA);
    step(0, add_x6, 1, 0, 0, 1, 5'd3, 64'hAA);
    settle();
    chk("reset_valid_e", {63'd0, valid_e}, 64'd0);
    chk("reset_rd1_e", rd1_e, 64'd0);

    step(1, add_x6, 1, 0, 0, 1, 5'd5, 64'h1234);
    settle();
    chk("bypass_rd1", rd1_e, 64'h1234);

    go(lw_x7);
    go(add_x8);
    chk("ldu_stall", {63'd0, stall_d}, 64'd1);
    settle();
    chk("ldu_bubble_regw", {63'd0, regwrite_e}, 64'd0);
    chk("ldu_bubble_valid", {63'd0, valid_e}, 64'd0);
    go(add_x8);
    settle();
    chk("ldu_issue_rd", 64'(rd_e), 64'd8);
    chk("ldu_issue_valid", {63'd0, valid_e}, 64'd1);

    go(sw_x8);
    for (int i = 0; i < 3; i++) step(1, add_x9, 1, 1, 0, 0, 5'd0, 64'd0);
    settle();
    chk("hold_memwrite", {63'd0, memwrite_e}, 64'd1);
    chk("hold_imm", imm_e, 64'd4);
    go(add_x9);
    settle();
    chk("release_rd", 64'(rd_e), 64'd9);

    step(1, add_x10, 1, 1, 1, 1, 5'd0, 64'hFFFF);
    settle();
    chk("flush_hold_valid", {63'd0, valid_e}, 64'd0);
    step(1, add_x10, 1, 0, 0, 1, 5'd0, 64'hFFFF);
    settle();
    chk("x0_read", rd1_e, 64'd0);

    step(1, 32'd0, 0, 0, 0, 1, 5'd20, 64'hDEAD);
    go(beq_m8);
    settle();
    chk("beq_imm", imm_e, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("beq_alu", 64'(alucontrol_e), 64'd1);
    chk("beq_branch", {63'd0, branch_e}, 64'd1);
    step(1, add_x11, 1, 0, 0, 1, 5'd20, 64'hBEEF);
    settle();
    chk("x20_read", rd1_e, 64'd0);

    go(lw_x3);
    go(add_x4);
    chk("mid_stall", {63'd0, stall_d}, 64'd1);
    step(0, add_x4, 1, 1, 1, 1, 5'd4, 64'h77);
    settle();
    chk("rst_stall_d", {63'd0, stall_d}, 64'd0);
    chk("rst_memread_e", {63'd0, memread_e}, 64'd0);
    go(add_x4);

    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 99) != 0, rand_instr(), $urandom_range(0, 99) < 88,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 31)), {$urandom, $urandom});
    end

    @(posedge clk); #3;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
